dma_chan_arbiter: RTL and testbench
===================================

# dma_chan_arbiter

Parametrised DMA channel priority and bus-hold arbiter for the 8237A-class controller, generalising the fixed four-channel priority logic to `NUM_CH` channels. It adds rotating priority, per-channel transfer modes, software requests and programmable DREQ/DACK polarity. It sits between the DREQ/DACK pins, the CPU HRQ/HLDA handshake and the timing-control block, which it tells which channel owns the bus and when service ends.

## Interface
- `NUM_CH`, 4: number of DMA channels, 2..8.
- `SYNC_STAGES`, 2: DREQ synchroniser depth, 1..3.
- `CW` (localparam): `$clog2(NUM_CH)`.
- `CLK` in 1: system clock; all state changes on posedge.
- `RESET` in 1: synchronous, active-high reset.
- `DREQ` in NUM_CH: asynchronous channel requests, polarity set by `CMD_DREQ_LOW`.
- `HLDA` in 1: CPU hold acknowledge, synchronous.
- `MASK` in NUM_CH: 1 = channel hardware request masked.
- `SW_REQ` in NUM_CH: software request bits, synchronous, not maskable.
- `CH_MODE` in 2*NUM_CH: per channel `{mode}` at bits [2k+1:2k]. 00 = demand, 01 = single, 10 = block, 11 = treated as single.
- `CMD_ROT_PRIO` in 1: 1 = rotating priority, 0 = fixed priority (ch0 highest).
- `CMD_DREQ_LOW` in 1: 1 = DREQ active-low.
- `CMD_DACK_HIGH` in 1: 1 = DACK active-high.
- `XFER_DONE` in 1: one-cycle pulse from timing control when one transfer completes.
- `TC_REACHED` in 1: qualifies `XFER_DONE`; the active channel's word count has expired.
- `EOP_IN` in 1: decoded external end-of-process, active-high.
- `HRQ` out 1: hold request to the CPU.
- `DACK` out NUM_CH: channel acknowledges, polarity per `CMD_DACK_HIGH`.
- `ACTIVE` out 1: a channel is in service; starts timing control.
- `ACT_CH` out CW: index of the serviced channel.
- `SWREQ_CLR` out NUM_CH: one-cycle pulse that clears `SW_REQ[k]` on TC or EOP.
- `REQ_STATUS` out NUM_CH: synchronised, polarity-corrected DREQ, for the status register.

## Operation
- Effective request per channel: `pend[k] = (dreq_s[k] & ~MASK[k]) | SW_REQ[k]`.
  - `dreq_s` is the last synchroniser stage, XORed with `CMD_DREQ_LOW`.
- Priority:
  - Fixed mode: lowest index wins.
  - Rotating mode: the search starts at pointer `rp` and wraps modulo NUM_CH. After a normal end of service on channel k, `rp` becomes (k+1) mod NUM_CH.
  - `rp` is held while `CMD_ROT_PRIO` = 0.
- States: IDLE, HOLD_REQ, SERVICE, RELEASE.
- IDLE:
  - any `pend` → HOLD_REQ, `HRQ` = 1.
- HOLD_REQ:
  - `HLDA` = 1 with `pend` ≠ 0 → SERVICE. The winner is latched into `ACT_CH`; `DACK[ACT_CH]` and `ACTIVE` are asserted.
  - `HLDA` = 1 with `pend` = 0 → RELEASE.
  - `HLDA` = 0 → stay; `HRQ` is held even if requests drop.
- SERVICE: an end of service is caused by any of the following.
  - `EOP_IN` = 1, with or without `XFER_DONE`.
  - `XFER_DONE` with `TC_REACHED`.
  - `XFER_DONE` in single mode.
  - `XFER_DONE` in demand mode with `pend[ACT_CH]` = 0.
  - Block mode continues until TC or EOP.
- Actions on end of service:
  - → RELEASE; `HRQ`, `ACTIVE` and `DACK` are deasserted.
  - `rp` is updated.
  - `SWREQ_CLR[ACT_CH]` pulses if the end was caused by TC or EOP.
- Abort in SERVICE: `HLDA` sampled 0 → IDLE. Outputs drop; there is no `rp` update and no `SWREQ_CLR`. Abort takes precedence over a simultaneous end of service.
- RELEASE:
  - `HLDA` = 0 → IDLE; otherwise wait.
- `ACT_CH` holds its value outside SERVICE.
- `EOP_IN`, `XFER_DONE` and `TC_REACHED` are ignored outside SERVICE.

## Timing
- All outputs are registered except `DACK` polarity, which is an XOR with `CMD_DACK_HIGH`, and `REQ_STATUS`.
- Reset values:
  - `HRQ` = 0, `ACTIVE` = 0, `ACT_CH` = 0, `SWREQ_CLR` = 0.
  - `DACK` all inactive.
  - `rp` = 0, state IDLE, synchronisers cleared.
- `RESET` during any state forces these values after that edge, regardless of `HLDA`.
- DREQ latency: DREQ first sampled active at edge 1 → `HRQ` = 1 after edge `SYNC_STAGES`+1, i.e. edge 3 by default.
- SW_REQ latency: `SW_REQ` sampled at edge 1 → `HRQ` = 1 after edge 1.
- Grant: `HLDA` sampled 1 at edge k → `DACK`, `ACTIVE` and `ACT_CH` valid after edge k. The winner is decided from `pend` at edge k.
- End of service: end condition at edge m → `HRQ`, `DACK` and `ACTIVE` low after edge m; `SWREQ_CLR` high for the cycle after edge m only.
- Re-request: the earliest new `HRQ` is one edge after re-entering IDLE.

## Test plan
- **Single mode, fixed priority, NUM_CH = 4:** DREQ[2] = 1, `HLDA` raised 2 cycles after `HRQ`, then one `XFER_DONE` → `HRQ` at edge 3, `DACK` = 0100 after the HLDA edge, `HRQ`/`DACK` low after the XFER_DONE edge, state back to IDLE when `HLDA` drops.
- **Rotating priority:** DREQ[0] and DREQ[1] held high, `CMD_ROT_PRIO` = 1, repeated single transfers → `ACT_CH` sequence 0, 1, 0, 1; with `CMD_ROT_PRIO` = 0 → 0, 0, 0.
- **Block mode with TC:** `SW_REQ[3]`, 5 `XFER_DONE` pulses, TC on the 5th → `DACK[3]` continuous for all 5, `SWREQ_CLR` = 1000 for one cycle.
- **Demand mode and EOP:**
  - DREQ[1] drops before the 3rd `XFER_DONE` → service ends at the 3rd pulse.
  - Repeat with `EOP_IN` mid-transfer and no `XFER_DONE` → ends at that edge.
- **Polarity and mask:** `CMD_DREQ_LOW` = 1, `CMD_DACK_HIGH` = 0, `MASK[0]` = 1 with DREQ[0] low and DREQ[1] low → channel 1 granted, `DACK` = 1101; masked channel 0 is never granted.
- **Abort and reset:**
  - `HLDA` dropped in SERVICE together with `XFER_DONE` + TC → IDLE, no `SWREQ_CLR`, `rp` unchanged.
  - `RESET` pulsed mid-SERVICE → all outputs at reset values next cycle.

Source files
------------

// File: rtl/dma_chan_arbiter.sv
// ---------------------------------------------------------------------------
// dma_chan_arbiter
//
// Channel priority and bus-hold arbiter for an 8237A-class DMA controller,
// generalised to NUM_CH channels.
//
// The block does four things:
//   - synchronises the DREQ pins;
//   - forms the effective per-channel request from DREQ, MASK and SW_REQ;
//   - runs the HRQ/HLDA handshake with the CPU;
//   - tells timing control which channel owns the bus, and ends service on
//     TC, EOP or the transfer-mode rules.
//
// Ports
//   CLK, RESET      : system clock; synchronous active-high reset
//   DREQ[NUM_CH]    : asynchronous channel requests (polarity: CMD_DREQ_LOW)
//   HLDA            : CPU hold acknowledge
//   MASK[NUM_CH]    : 1 = hardware request of that channel masked
//   SW_REQ[NUM_CH]  : software requests, not maskable
//   CH_MODE[2*N]    : per-channel mode, 00 demand, 01 single, 10 block,
//                     11 single
//   CMD_ROT_PRIO    : 1 = rotating priority, 0 = fixed (ch0 highest)
//   CMD_DREQ_LOW    : 1 = DREQ pins active-low
//   CMD_DACK_HIGH   : 1 = DACK pins active-high
//   XFER_DONE       : one-cycle pulse per completed transfer
//   TC_REACHED      : qualifies XFER_DONE, word count expired
//   EOP_IN          : external end-of-process, active-high
//   HRQ             : hold request to the CPU
//   DACK[NUM_CH]    : channel acknowledges
//   ACTIVE          : a channel is in service
//   ACT_CH[CW]      : index of the serviced channel
//   SWREQ_CLR[N]    : one-cycle pulse clearing SW_REQ on TC/EOP
//   REQ_STATUS[N]   : synchronised, polarity-corrected DREQ
// ---------------------------------------------------------------------------
module dma_chan_arbiter #(
   parameter int  NUM_CH      = 4,
   parameter int  SYNC_STAGES = 2,
   localparam int CW          = $clog2(NUM_CH)
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [NUM_CH-1:0]     DREQ,
   input  logic                  HLDA,
   input  logic [NUM_CH-1:0]     MASK,
   input  logic [NUM_CH-1:0]     SW_REQ,
   input  logic [2*NUM_CH-1:0]   CH_MODE,
   input  logic                  CMD_ROT_PRIO,
   input  logic                  CMD_DREQ_LOW,
   input  logic                  CMD_DACK_HIGH,
   input  logic                  XFER_DONE,
   input  logic                  TC_REACHED,
   input  logic                  EOP_IN,
   output logic                  HRQ,
   output logic [NUM_CH-1:0]     DACK,
   output logic                  ACTIVE,
   output logic [CW-1:0]         ACT_CH,
   output logic [NUM_CH-1:0]     SWREQ_CLR,
   output logic [NUM_CH-1:0]     REQ_STATUS
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_HOLD_REQ = 2'd1,
      ST_SERVICE  = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   localparam logic [1:0] MODE_DEMAND = 2'b00;
   localparam logic [1:0] MODE_BLOCK  = 2'b10;

   // Winner search: channels at or above `start` first, then wrap to 0.
   // With start = 0 this degenerates to plain fixed priority.
   function automatic logic [CW-1:0] pick_winner(input logic [NUM_CH-1:0] req,
                                                 input logic [CW-1:0]     start);
      logic [CW-1:0] win;
      logic          found;
      win   = '0;
      found = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (!found && req[c] && (CW'(c) >= start)) begin
            win   = CW'(c);
            found = 1'b1;
         end
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (!found && req[c]) begin
            win   = CW'(c);
            found = 1'b1;
         end
      end
      return win;
   endfunction

   function automatic logic [CW-1:0] next_ptr(input logic [CW-1:0] ch);
      return CW'((int'(ch) + 1) % NUM_CH);
   endfunction

   function automatic logic [1:0] mode_of(input logic [2*NUM_CH-1:0] modes,
                                          input logic [CW-1:0]       ch);
      logic [1:0] m;
      m = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (CW'(k) == ch) m = modes[2*k +: 2];
      end
      return m;
   endfunction

   // ---- DREQ synchroniser ----
   logic [NUM_CH-1:0] dreq_sync [SYNC_STAGES];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < SYNC_STAGES; i++) dreq_sync[i] <= '0;
      end else begin
         dreq_sync[0] <= DREQ;
         for (int i = 1; i < SYNC_STAGES; i++) dreq_sync[i] <= dreq_sync[i-1];
      end
   end

   // ---- request qualification and end-of-service decode ----
   logic [NUM_CH-1:0] dreq_s;
   logic [NUM_CH-1:0] pend;
   logic [CW-1:0]     winner;
   logic [NUM_CH-1:0] winner_oh;
   logic [1:0]        cur_mode;
   logic              cur_req;
   logic              tc_hit;
   logic              mode_end;
   logic              svc_end;

   state_t            state, state_d;
   logic              hrq_q, hrq_d;
   logic              active_q, active_d;
   logic [CW-1:0]     act_ch_q, act_ch_d;
   logic [NUM_CH-1:0] dack_q, dack_d;
   logic [NUM_CH-1:0] swreq_clr_q, swreq_clr_d;
   logic [CW-1:0]     rp_q, rp_d;

   always_comb begin
      dreq_s    = dreq_sync[SYNC_STAGES-1] ^ {NUM_CH{CMD_DREQ_LOW}};
      pend      = (dreq_s & ~MASK) | SW_REQ;
      winner    = pick_winner(pend, CMD_ROT_PRIO ? rp_q : '0);
      winner_oh = {{(NUM_CH-1){1'b0}}, 1'b1} << winner;
      cur_mode  = mode_of(CH_MODE, act_ch_q);
      // dack_q is one-hot on the active channel while in service, so it
      // doubles as the select for that channel's own request.
      cur_req   = |(pend & dack_q);
      tc_hit    = XFER_DONE & TC_REACHED;
      case (cur_mode)
         MODE_DEMAND: mode_end = XFER_DONE & ~cur_req;
         MODE_BLOCK:  mode_end = 1'b0;
         default:     mode_end = XFER_DONE;   // 01 and 11: single
      endcase
      svc_end   = EOP_IN | tc_hit | mode_end;
   end

   // ---- arbitration FSM, next state and registered outputs ----
   always_comb begin
      state_d     = state;
      hrq_d       = hrq_q;
      active_d    = active_q;
      act_ch_d    = act_ch_q;
      dack_d      = dack_q;
      swreq_clr_d = '0;
      rp_d        = rp_q;

      case (state)
         ST_IDLE: begin
            hrq_d    = |pend;
            active_d = 1'b0;
            dack_d   = '0;
            if (|pend) state_d = ST_HOLD_REQ;
         end

         ST_HOLD_REQ: begin
            // HRQ stays up even if every request vanishes before HLDA.
            hrq_d = 1'b1;
            if (HLDA) begin
               if (|pend) begin
                  state_d  = ST_SERVICE;
                  act_ch_d = winner;
                  active_d = 1'b1;
                  dack_d   = winner_oh;
               end else begin
                  state_d = ST_RELEASE;
                  hrq_d   = 1'b0;
               end
            end
         end

         ST_SERVICE: begin
            // Losing HLDA wins over any end condition in the same cycle:
            // no pointer update, no software-request clear.
            if (!HLDA) begin
               state_d  = ST_IDLE;
               hrq_d    = 1'b0;
               active_d = 1'b0;
               dack_d   = '0;
            end else if (svc_end) begin
               state_d  = ST_RELEASE;
               hrq_d    = 1'b0;
               active_d = 1'b0;
               dack_d   = '0;
               if (CMD_ROT_PRIO) rp_d = next_ptr(act_ch_q);
               if (EOP_IN | tc_hit) swreq_clr_d = dack_q;
            end
         end

         ST_RELEASE: begin
            hrq_d    = 1'b0;
            active_d = 1'b0;
            dack_d   = '0;
            if (!HLDA) state_d = ST_IDLE;
         end

         default: begin
            state_d  = ST_IDLE;
            hrq_d    = 1'b0;
            active_d = 1'b0;
            dack_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= ST_IDLE;
         hrq_q       <= 1'b0;
         active_q    <= 1'b0;
         act_ch_q    <= '0;
         dack_q      <= '0;
         swreq_clr_q <= '0;
         rp_q        <= '0;
      end else begin
         state       <= state_d;
         hrq_q       <= hrq_d;
         active_q    <= active_d;
         act_ch_q    <= act_ch_d;
         dack_q      <= dack_d;
         swreq_clr_q <= swreq_clr_d;
         rp_q        <= rp_d;
      end
   end

   // ---- output polarity ----
   assign HRQ        = hrq_q;
   assign ACTIVE     = active_q;
   assign ACT_CH     = act_ch_q;
   assign SWREQ_CLR  = swreq_clr_q;
   assign DACK       = dack_q ^ {NUM_CH{~CMD_DACK_HIGH}};
   assign REQ_STATUS = dreq_s;

endmodule

// File: tb/tb_dma_chan_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dma_chan_arbiter
//
// Self-checking bench for dma_chan_arbiter with NUM_CH = 4, SYNC_STAGES = 2.
//
// A behavioural reference model tracks the handshake as a set of flags:
// waiting for HLDA, serving, releasing. It predicts every output after every
// clock edge.
//
// On top of the model the bench runs:
//   - a table of cycle vectors for the basic single-mode transaction;
//   - hand-written sequences for rotation, block/TC, demand/EOP, polarity
//     with masking, abort and reset;
//   - a randomised run.
// ---------------------------------------------------------------------------
module tb_dma_chan_arbiter;

   localparam int NCH = 4;
   localparam int SYN = 2;

   logic             CLK;
   logic             RESET;
   logic [NCH-1:0]   DREQ;
   logic             HLDA;
   logic [NCH-1:0]   MASK;
   logic [NCH-1:0]   SW_REQ;
   logic [2*NCH-1:0] CH_MODE;
   logic             CMD_ROT_PRIO;
   logic             CMD_DREQ_LOW;
   logic             CMD_DACK_HIGH;
   logic             XFER_DONE;
   logic             TC_REACHED;
   logic             EOP_IN;
   logic             HRQ;
   logic [NCH-1:0]   DACK;
   logic             ACTIVE;
   logic [1:0]       ACT_CH;
   logic [NCH-1:0]   SWREQ_CLR;
   logic [NCH-1:0]   REQ_STATUS;

   dma_chan_arbiter #(.NUM_CH(NCH), .SYNC_STAGES(SYN)) dut (
      .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .MASK(MASK),
      .SW_REQ(SW_REQ), .CH_MODE(CH_MODE), .CMD_ROT_PRIO(CMD_ROT_PRIO),
      .CMD_DREQ_LOW(CMD_DREQ_LOW), .CMD_DACK_HIGH(CMD_DACK_HIGH),
      .XFER_DONE(XFER_DONE), .TC_REACHED(TC_REACHED), .EOP_IN(EOP_IN),
      .HRQ(HRQ), .DACK(DACK), .ACTIVE(ACTIVE), .ACT_CH(ACT_CH),
      .SWREQ_CLR(SWREQ_CLR), .REQ_STATUS(REQ_STATUS)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [NCH-1:0] m_sync [SYN];
   bit             m_req  = 0;   // HRQ raised, waiting for HLDA
   bit             m_serv = 0;   // channel m_ch owns the bus
   bit             m_rel  = 0;   // service over, waiting for HLDA to drop
   int             m_ch   = 0;
   int             m_rp   = 0;
   logic [NCH-1:0] m_clr  = '0;

   task automatic model_step();
      logic [NCH-1:0] p;
      logic [1:0]     md;
      int             win;
      int             start;
      bit             tc;
      bit             fin;
      p     = ((m_sync[SYN-1] ^ {NCH{CMD_DREQ_LOW}}) & ~MASK) | SW_REQ;
      start = CMD_ROT_PRIO ? m_rp : 0;
      win   = -1;
      for (int i = 0; i < NCH; i++)
         if (win < 0 && p[(start + i) % NCH]) win = (start + i) % NCH;
      m_clr = '0;
      if (RESET) begin
         m_req = 0; m_serv = 0; m_rel = 0; m_ch = 0; m_rp = 0;
      end else if (m_req) begin
         if (HLDA) begin
            m_req = 0;
            if (win >= 0) begin m_serv = 1; m_ch = win; end
            else m_rel = 1;
         end
      end else if (m_serv) begin
         if (!HLDA) m_serv = 0;
         else begin
            md  = CH_MODE[2*m_ch +: 2];
            tc  = XFER_DONE && TC_REACHED;
            fin = EOP_IN || tc
                  || (XFER_DONE && (md == 2'b01 || md == 2'b11))
                  || (XFER_DONE && md == 2'b00 && !p[m_ch]);
            if (fin) begin
               m_serv = 0;
               m_rel  = 1;
               if (CMD_ROT_PRIO) m_rp = (m_ch + 1) % NCH;
               if (EOP_IN || tc) m_clr = 4'b0001 << m_ch;
            end
         end
      end else if (m_rel) begin
         if (!HLDA) m_rel = 0;
      end else if (p != 0) begin
         m_req = 1;
      end
      if (RESET) begin
         for (int i = 0; i < SYN; i++) m_sync[i] = '0;
      end else begin
         for (int i = SYN - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
         m_sync[0] = DREQ;
      end
   endtask

   // One clock: advance the model, pass the edge, compare every output.
   task automatic tick();
      logic [NCH-1:0] e_dack;
      model_step();
      @(posedge CLK);
      #1;
      e_dack = (m_serv ? (4'b0001 << m_ch) : 4'b0000) ^ (CMD_DACK_HIGH ? 4'b0000 : 4'b1111);
      chk("m_hrq",    32'(HRQ),        32'(m_req | m_serv));
      chk("m_active", 32'(ACTIVE),     32'(m_serv));
      chk("m_act_ch", 32'(ACT_CH),     32'(m_ch));
      chk("m_dack",   32'(DACK),       32'(e_dack));
      chk("m_swclr",  32'(SWREQ_CLR),  32'(m_clr));
      chk("m_reqst",  32'(REQ_STATUS), 32'(m_sync[SYN-1] ^ {NCH{CMD_DREQ_LOW}}));
   endtask

   task automatic set_defaults();
      RESET = 0; DREQ = '0; HLDA = 0; MASK = '0; SW_REQ = '0;
      CH_MODE = 8'b01_01_01_01; CMD_ROT_PRIO = 0; CMD_DREQ_LOW = 0;
      CMD_DACK_HIGH = 1; XFER_DONE = 0; TC_REACHED = 0; EOP_IN = 0;
   endtask

   task automatic do_reset();
      RESET = 1; HLDA = 0;
      tick();
      RESET = 0;
   endtask

   task automatic wait_hrq(input string nm);
      int n;
      n = 0;
      while (HRQ !== 1'b1 && n < 20) begin tick(); n++; end
      chk(nm, 32'(HRQ), 32'd1);
   endtask

   // Request already pending: grant, one single-mode transfer, release.
   task automatic serve_once(output int ch);
      HLDA = 0;
      wait_hrq("serve_hrq");
      HLDA = 1;
      tick();
      ch = int'(ACT_CH);
      chk("serve_active", 32'(ACTIVE), 32'd1);
      XFER_DONE = 1;
      tick();
      XFER_DONE = 0;
      chk("serve_end_hrq", 32'(HRQ), 32'd0);
      HLDA = 0;
      tick();
   endtask

   typedef struct {
      logic       rst;
      logic [3:0] dreq;
      logic       hlda;
      logic [3:0] sw;
      logic       xfer;
      logic       e_hrq;
      logic       e_act;
      logic [3:0] e_dack;
      logic [1:0] e_ch;
   } vec_t;

   vec_t tbl [15];

   initial begin
      int ch;
      int rot_exp [4];

      //            rst   dreq     hlda  sw       xfer  hrq   act   dack     ch
      tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0};
      tbl[1]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0};
      tbl[2]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0};
      tbl[3]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0};
      tbl[4]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0};
      tbl[5]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0100, 2'd2};
      tbl[6]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0100, 2'd2};
      tbl[7]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd2};
      tbl[8]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2};
      tbl[9]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2};
      tbl[10] = '{1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd2};
      tbl[11] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd2};
      tbl[12] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2};
      tbl[13] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2};
      tbl[14] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2};

      for (int i = 0; i < SYN; i++) m_sync[i] = '0;
      set_defaults();

      // ---- single mode, fixed priority, cycle by cycle ----
      for (int r = 0; r < 15; r++) begin
         RESET = tbl[r].rst; DREQ = tbl[r].dreq; HLDA = tbl[r].hlda;
         SW_REQ = tbl[r].sw; XFER_DONE = tbl[r].xfer;
         tick();
         chk($sformatf("tbl%0d_hrq", r),    32'(HRQ),    32'(tbl[r].e_hrq));
         chk($sformatf("tbl%0d_active", r), 32'(ACTIVE), 32'(tbl[r].e_act));
         chk($sformatf("tbl%0d_dack", r),   32'(DACK),   32'(tbl[r].e_dack));
         chk($sformatf("tbl%0d_act_ch", r), 32'(ACT_CH), 32'(tbl[r].e_ch));
      end
      RESET = 0; XFER_DONE = 0; SW_REQ = '0;

      // ---- rotating priority, then fixed ----
      set_defaults();
      DREQ = 4'b0011; CMD_ROT_PRIO = 1;
      do_reset();
      rot_exp = '{0, 1, 0, 1};
      for (int i = 0; i < 4; i++) begin
         serve_once(ch);
         chk($sformatf("rot_seq%0d", i), 32'(ch), 32'(rot_exp[i]));
      end
      CMD_ROT_PRIO = 0;
      for (int i = 0; i < 3; i++) begin
         serve_once(ch);
         chk($sformatf("fix_seq%0d", i), 32'(ch), 32'd0);
      end

      // ---- block mode ended by TC on the fifth transfer ----
      set_defaults();
      CH_MODE = 8'b10_01_01_01; SW_REQ = 4'b1000;
      do_reset();
      wait_hrq("blk_hrq");
      HLDA = 1;
      tick();
      chk("blk_grant", 32'(DACK), 32'h8);
      for (int i = 0; i < 5; i++) begin
         XFER_DONE = 1; TC_REACHED = (i == 4);
         tick();
         XFER_DONE = 0; TC_REACHED = 0;
         if (i < 4) begin
            chk($sformatf("blk_dack%0d", i), 32'(DACK), 32'h8);
            tick();
            chk($sformatf("blk_gap%0d", i), 32'(DACK), 32'h8);
         end else begin
            chk("blk_end_dack", 32'(DACK), 32'h0);
            chk("blk_swclr", 32'(SWREQ_CLR), 32'h8);
         end
      end
      SW_REQ = '0;
      tick();
      chk("blk_swclr_once", 32'(SWREQ_CLR), 32'h0);
      HLDA = 0;
      tick();

      // ---- demand mode: request drops before the third transfer ----
      set_defaults();
      CH_MODE = 8'b01_01_00_01; DREQ = 4'b0010;
      do_reset();
      wait_hrq("dem_hrq");
      HLDA = 1;
      tick();
      chk("dem_ch", 32'(ACT_CH), 32'd1);
      for (int i = 0; i < 2; i++) begin
         XFER_DONE = 1; tick(); XFER_DONE = 0;
         chk($sformatf("dem_keep%0d", i), 32'(ACTIVE), 32'd1);
         tick();
      end
      DREQ = 4'b0000;
      tick(); tick();
      chk("dem_wait_xfer", 32'(ACTIVE), 32'd1);
      XFER_DONE = 1; tick(); XFER_DONE = 0;
      chk("dem_end", 32'(ACTIVE), 32'd0);
      chk("dem_no_swclr", 32'(SWREQ_CLR), 32'd0);
      HLDA = 0;
      tick();

      // ---- demand mode ended by EOP with no transfer pulse ----
      DREQ = 4'b0010;
      wait_hrq("eop_hrq");
      HLDA = 1;
      tick(); tick();
      chk("eop_active", 32'(ACTIVE), 32'd1);
      EOP_IN = 1; tick(); EOP_IN = 0;
      chk("eop_end", 32'(ACTIVE), 32'd0);
      chk("eop_hrq_low", 32'(HRQ), 32'd0);
      chk("eop_swclr", 32'(SWREQ_CLR), 32'h2);
      tick();
      chk("eop_swclr_once", 32'(SWREQ_CLR), 32'h0);
      HLDA = 0;
      tick();

      // ---- active-low DREQ, active-low DACK, channel 0 masked ----
      set_defaults();
      CMD_DREQ_LOW = 1; CMD_DACK_HIGH = 0; MASK = 4'b0001; DREQ = 4'b1100;
      do_reset();
      for (int i = 0; i < 4; i++) tick();
      chk("pol_reqstat", 32'(REQ_STATUS), 32'h3);
      chk("pol_hrq", 32'(HRQ), 32'd1);
      HLDA = 1;
      tick();
      chk("pol_ch", 32'(ACT_CH), 32'd1);
      chk("pol_dack", 32'(DACK), 32'hD);
      XFER_DONE = 1; tick(); XFER_DONE = 0;
      chk("pol_dack_idle", 32'(DACK), 32'hF);
      HLDA = 0;
      tick();
      serve_once(ch);
      chk("mask_ch0_never", 32'(ch), 32'd1);

      // ---- abort beats a simultaneous TC end ----
      set_defaults();
      CMD_ROT_PRIO = 1; SW_REQ = 4'b0001; DREQ = 4'b0010;
      do_reset();
      wait_hrq("abt_hrq");
      HLDA = 1;
      tick();
      chk("abt_ch", 32'(ACT_CH), 32'd0);
      HLDA = 0; XFER_DONE = 1; TC_REACHED = 1;
      tick();
      XFER_DONE = 0; TC_REACHED = 0;
      chk("abt_active", 32'(ACTIVE), 32'd0);
      chk("abt_hrq", 32'(HRQ), 32'd0);
      chk("abt_no_swclr", 32'(SWREQ_CLR), 32'd0);
      serve_once(ch);
      chk("abt_rp_kept", 32'(ch), 32'd0);
      SW_REQ = '0;

      // ---- reset in the middle of service ----
      set_defaults();
      DREQ = 4'b0100;
      do_reset();
      wait_hrq("rst_hrq");
      HLDA = 1;
      tick();
      chk("rst_pre_dack", 32'(DACK), 32'h4);
      RESET = 1; XFER_DONE = 1; TC_REACHED = 1;
      tick();
      RESET = 0; XFER_DONE = 0; TC_REACHED = 0;
      chk("rst_hrq0", 32'(HRQ), 32'd0);
      chk("rst_active0", 32'(ACTIVE), 32'd0);
      chk("rst_ch0", 32'(ACT_CH), 32'd0);
      chk("rst_dack0", 32'(DACK), 32'h0);
      chk("rst_swclr0", 32'(SWREQ_CLR), 32'h0);
      chk("rst_reqst0", 32'(REQ_STATUS), 32'h0);
      HLDA = 0;
      tick();
      chk("rst_idle_hrq", 32'(HRQ), 32'd0);

      // ---- randomised run against the model ----
      set_defaults();
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 64 == 0) begin
            CH_MODE      = 8'($urandom);
            CMD_ROT_PRIO = 1'($urandom);
            MASK         = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
         end
         if (cyc % 256 == 128) begin
            CMD_DREQ_LOW  = 1'($urandom);
            CMD_DACK_HIGH = 1'($urandom);
         end
         for (int k = 0; k < NCH; k++)
            if ($urandom_range(0, 7) == 0) DREQ[k] = ~DREQ[k];
         SW_REQ = SW_REQ & ~m_clr;
         for (int k = 0; k < NCH; k++)
            if ($urandom_range(0, 39) == 0) SW_REQ[k] = 1'b1;
         HLDA       = ($urandom_range(0, 19) == 0) ? ~(m_req | m_serv) : (m_req | m_serv);
         XFER_DONE  = ($urandom_range(0, 2) == 0);
         TC_REACHED = ($urandom_range(0, 9) == 0);
         EOP_IN     = ($urandom_range(0, 29) == 0);
         RESET      = ($urandom_range(0, 199) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
